// File: rtl/pim_mac_job_sequencer_if.sv
// Handshake bundle between the PIM MAC job sequencer and its job source, weight stream,
// PIM CFU cmd/rsp port and result sink. The master modport is the sequencer's own view.
interface pim_mac_job_sequencer_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
);
    logic              start_valid;
    logic              start_ready;
    logic [7:0]        start_base;
    logic [8:0]        start_words;
    logic [5:0]        start_steps;

    logic              w_valid;
    logic              w_ready;
    logic [DWIDTH-1:0] w_data;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [AWIDTH-1:0] cmd_payload_function_id;
    logic [DWIDTH-1:0] cmd_payload_inputs_0;
    logic [DWIDTH-1:0] cmd_payload_inputs_1;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_payload_response_ok;
    logic [DWIDTH-1:0] rsp_payload_outputs_0;

    logic              res_valid;
    logic              res_ready;
    logic [DWIDTH-1:0] res_data;
    logic              res_err;

    logic              busy;

    modport master (
        input  start_valid, start_base, start_words, start_steps,
        input  w_valid, w_data,
        input  cmd_ready,
        input  rsp_valid, rsp_payload_response_ok, rsp_payload_outputs_0,
        input  res_ready,
        output start_ready, w_ready,
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        output rsp_ready,
        output res_valid, res_data, res_err,
        output busy
    );

    modport slave (
        output start_valid, start_base, start_words, start_steps,
        output w_valid, w_data,
        output cmd_ready,
        output rsp_valid, rsp_payload_response_ok, rsp_payload_outputs_0,
        output res_ready,
        input  start_ready, w_ready,
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        input  rsp_ready,
        input  res_valid, res_data, res_err,
        input  busy
    );
endinterface

// File: rtl/pim_mac_job_sequencer.sv
// Job-level sequencer for the PIM CFU: writes a stream of weight words into consecutive
// rows, then issues a programmed number of MAC steps and returns the last MAC output.
module pim_mac_job_sequencer #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    pim_mac_job_sequencer_if.master bus
);

    localparam logic [AWIDTH-1:0] FID_NONE  = '0;
    localparam logic [AWIDTH-1:0] FID_WRITE = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] FID_MAC   = AWIDTH'(2);
    localparam logic [6:0]        TMO_LAST  = 7'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        base_q, base_d;
    logic [8:0]        words_q, words_d;
    logic [8:0]        word_cnt_q, word_cnt_d;
    logic [5:0]        steps_q, steps_d;
    logic [5:0]        step_cnt_q, step_cnt_d;
    logic [6:0]        tmo_cnt_q, tmo_cnt_d;
    logic [AWIDTH-1:0] fid_q, fid_d;
    logic [DWIDTH-1:0] in0_q, in0_d;
    logic [DWIDTH-1:0] in1_q, in1_d;
    logic [DWIDTH-1:0] res_data_q, res_data_d;
    logic              res_err_q, res_err_d;
    logic [8:0]        word_nxt;
    logic [5:0]        step_nxt;

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (v == 7'h7f) ? v : v + 7'd1;
    endfunction

    function automatic logic [DWIDTH-1:0] row_word(input logic [7:0] row);
        return {{(DWIDTH-8){1'b0}}, row};
    endfunction

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        words_d    = words_q;
        word_cnt_d = word_cnt_q;
        steps_d    = steps_q;
        step_cnt_d = step_cnt_q;
        tmo_cnt_d  = '0;
        fid_d      = fid_q;
        in0_d      = in0_q;
        in1_d      = in1_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        word_nxt   = word_cnt_q + 9'd1;
        step_nxt   = step_cnt_q + 6'd1;

        unique case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    base_d     = bus.start_base;
                    words_d    = bus.start_words;
                    steps_d    = bus.start_steps;
                    word_cnt_d = '0;
                    step_cnt_d = '0;
                    res_data_d = '0;
                    res_err_d  = 1'b0;
                    if (bus.start_words != '0) begin
                        state_d = FETCH;
                    end else if (bus.start_steps != '0) begin
                        state_d = ISSUE;
                        fid_d   = FID_MAC;
                        in0_d   = '0;
                        in1_d   = row_word(bus.start_base);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                if (bus.w_valid) begin
                    state_d = ISSUE;
                    fid_d   = FID_WRITE;
                    in0_d   = bus.w_data;
                    in1_d   = row_word(base_q + word_cnt_q[7:0]);
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                tmo_cnt_d = sat_inc7(tmo_cnt_q);
                if (bus.rsp_valid && !bus.rsp_payload_response_ok) begin
                    res_err_d = 1'b1;
                    state_d   = DONE;
                end else if (bus.rsp_valid && fid_q == FID_MAC) begin
                    res_data_d = bus.rsp_payload_outputs_0;
                    step_cnt_d = step_nxt;
                    state_d    = (step_nxt < steps_q) ? ISSUE : DONE;
                end else if (bus.rsp_valid) begin
                    word_cnt_d = word_nxt;
                    if (word_nxt < words_q) begin
                        state_d = FETCH;
                    end else if (steps_q != '0) begin
                        state_d = ISSUE;
                        fid_d   = FID_MAC;
                        in0_d   = '0;
                        in1_d   = row_word(base_q);
                    end else begin
                        state_d = DONE;
                    end
                end else if (tmo_cnt_q >= TMO_LAST) begin
                    res_err_d = 1'b1;
                    state_d   = DONE;
                end
                // Payload is held through the capture cycle, then parked at zero
                if (state_d != WAIT && state_d != ISSUE) begin
                    fid_d = FID_NONE;
                    in0_d = '0;
                    in1_d = '0;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            words_q    <= '0;
            word_cnt_q <= '0;
            steps_q    <= '0;
            step_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            fid_q      <= FID_NONE;
            in0_q      <= '0;
            in1_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            words_q    <= words_d;
            word_cnt_q <= word_cnt_d;
            steps_q    <= steps_d;
            step_cnt_q <= step_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            fid_q      <= fid_d;
            in0_q      <= in0_d;
            in1_q      <= in1_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them immediately
    assign bus.start_ready             = (state_q == IDLE);
    assign bus.busy                    = (state_q != IDLE);
    assign bus.w_ready                 = (state_q == FETCH);
    assign bus.cmd_valid               = (state_q == ISSUE);
    assign bus.rsp_ready               = (state_q == WAIT);
    assign bus.res_valid               = (state_q == DONE);
    assign bus.cmd_payload_function_id = fid_q;
    assign bus.cmd_payload_inputs_0    = in0_q;
    assign bus.cmd_payload_inputs_1    = in1_q;
    assign bus.res_data                = res_data_q;
    assign bus.res_err                 = res_err_q;

endmodule

// File: doc/pim_mac_job_sequencer.md
# pim_mac_job_sequencer

Job-level controller that sits in front of the PIM CFU and drives its cmd/rsp port. For each accepted job it streams weight words into consecutive PIM rows with write commands, then issues a programmed number of bit-serial MAC steps. It returns the CFU output captured on the last MAC response as a single result, with an error flag. It replaces hand-sequenced CPU custom instructions for the load-then-MAC flow.

## Interface
- DWIDTH, 32, CFU data and payload width
- AWIDTH, 10, width of cmd_payload_function_id
- TIMEOUT, 64, max wait cycles for rsp_valid per CFU command (≥2)
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start_valid / start_ready  in / out  1 / 1  job handshake
- start_base  in  8  first PIM row address
- start_words  in  9  weight words to write (0..256)
- start_steps  in  6  MAC steps to issue (0..32)
- w_valid / w_ready  in / out  1 / 1  weight stream handshake
- w_data  in  DWIDTH  weight word
- cmd_valid  out  1  CFU command strobe
- cmd_ready  in  1  CFU ready (registered in CFU, monitored only)
- cmd_payload_function_id  out  AWIDTH  1 = write, 2 = MAC, 0 when idle
- cmd_payload_inputs_0  out  DWIDTH  write data (0 for MAC)
- cmd_payload_inputs_1  out  DWIDTH  {24'b0, row address}
- rsp_valid / rsp_ready  in / out  1 / 1  CFU response handshake
- rsp_payload_response_ok  in  1  CFU status
- rsp_payload_outputs_0  in  DWIDTH  CFU result
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_data  out  DWIDTH  MAC result
- res_err  out  1  job aborted
- busy  out  1  high from job accept until result accepted

## Operation
- FSM states: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid, latch base, words, steps; clear word and step counters and result.
  - If words>0, go to FETCH. Else if steps>0, go to ISSUE with MAC. Else go to DONE with res_data=0.
- FETCH:
  - w_ready=1.
  - On w_valid, latch w_data, go to ISSUE with write at row (base+word_cnt) mod 256. Row address wraps 255→0.
- ISSUE: cmd_valid=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - cmd_valid=0, rsp_ready=1.
  - On rsp_valid with response_ok=1:
    - After a write: increment word_cnt. If word_cnt<words, go to FETCH. Else if steps>0, go to ISSUE with MAC. Else go to DONE with res_data=0.
    - After a MAC: res_data ← outputs_0, increment step_cnt. If step_cnt<steps, go to ISSUE. Else go to DONE.
  - On rsp_valid with response_ok=0, or after TIMEOUT cycles in WAIT with no rsp_valid: set res_err=1, go to DONE.
- DONE: res_valid=1. On res_ready, clear res_valid and res_err, go to IDLE.
- function_id, inputs_0 and inputs_1 are registered. They are stable from ISSUE through the capture cycle, because the CFU output register follows function_id every cycle.
- start_valid is ignored while not in IDLE. w_valid is ignored outside FETCH.

## Timing
- Reset values: start_ready=1, busy=0, w_ready=0, cmd_valid=0, function_id=0, inputs_0=0, inputs_1=0, rsp_ready=0, res_valid=0, res_data=0, res_err=0.
- Asserting reset mid-job forces IDLE immediately. Counters clear, the job is dropped, and cmd_valid falls asynchronously.
- Against the CFU's one-cycle registered response:
  - Each command takes 2 cycles (ISSUE, WAIT).
  - Each write takes ≥3 cycles including FETCH.
- Best-case job latency from start accept to res_valid: 3·words + 2·steps + 1 cycles.
- A single-cycle cmd_valid pulse guarantees the CFU executes each MAC step exactly once.
- The TIMEOUT counter is 7 bits, cleared on each ISSUE. It saturates; it never wraps.
- Simultaneous start_valid with res_ready in DONE: the new job is not accepted until the cycle after return to IDLE.

## Test plan
- words=2, base=0x10, w_data=0xA5A5A5A5,0x5A5A5A5A, steps=0 -> write cmds at rows 0x10,0x11 with function_id=1; res_data=0, res_err=0.
- base=0xFF, words=2 -> write rows 0xFF then 0x00 (wrap).
- words=0, steps=4, CFU model returns 7,8,9,10 -> exactly 4 one-cycle MAC pulses; res_data=10.
- CFU model withholds rsp_valid -> res_err=1 after 64 WAIT cycles; cmd_valid stays 0 afterwards.
- response_ok=0 on first write -> res_err=1, no further commands; res_ready held low 5 cycles -> res_valid/res_data held.
- reset asserted in WAIT of step 2 -> all outputs return to reset values that cycle; a new job then completes normally.
